// File: rtl/siphash_core_pkg.sv
// -----------------------------------------------------------------------------
// siphash_core_pkg
// Shared definitions for the SipHash-2-4 core: initialisation constants,
// finalisation constant, SipRound rotation amounts, FSM state encoding,
// block-kind tag, the packed 4x64 internal state and a 64-bit rotate helper.
// -----------------------------------------------------------------------------
package siphash_core_pkg;

  // Initialisation constants ("somepseudorandomlygeneratedbytes").
  localparam logic [63:0] V0_INIT = 64'h736f_6d65_7073_6575;
  localparam logic [63:0] V1_INIT = 64'h646f_7261_6e64_6f6d;
  localparam logic [63:0] V2_INIT = 64'h6c79_6765_6e65_7261;
  localparam logic [63:0] V3_INIT = 64'h7465_6462_7974_6573;

  // XORed into v2 before the finalisation rounds.
  localparam logic [63:0] FIN_XOR = 64'h0000_0000_0000_00ff;

  // SipRound rotation amounts, in the order they are applied.
  localparam int unsigned ROT_V1_A = 13;
  localparam int unsigned ROT_V3_A = 16;
  localparam int unsigned ROT_V3_B = 21;
  localparam int unsigned ROT_V1_B = 17;
  localparam int unsigned ROT_HALF = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_C2,
    ST_PAD,
    ST_FIN,
    ST_DONE
  } state_e;

  // What the block currently being compressed means for the step after C2.
  typedef enum logic [1:0] {
    BLK_MID,        // more words follow
    BLK_LAST_FULL,  // final word was a full 8 bytes, a length-only block follows
    BLK_LAST        // block carried the length byte, finalisation follows
  } blk_kind_e;

  typedef struct packed {
    logic [63:0] v3;
    logic [63:0] v2;
    logic [63:0] v1;
    logic [63:0] v0;
  } sip_state_t;

  function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned n);
    return (x << n) | (x >> (64 - n));
  endfunction

endpackage

// File: rtl/sip_round_comb.sv
// -----------------------------------------------------------------------------
// sip_round_comb
// One SipRound, purely combinational. Shared by every state of siphash_core.
// Ports:
//   v0_i..v3_i  in   64  state before the round
//   v0_o..v3_o  out  64  state after the round
// -----------------------------------------------------------------------------
module sip_round_comb
  import siphash_core_pkg::*;
(
  input  logic [63:0] v0_i,
  input  logic [63:0] v1_i,
  input  logic [63:0] v2_i,
  input  logic [63:0] v3_i,
  output logic [63:0] v0_o,
  output logic [63:0] v1_o,
  output logic [63:0] v2_o,
  output logic [63:0] v3_o
);

  // Each intermediate gets its own name so the dataflow reads top to bottom
  // like the ARX description of the round.
  logic [63:0] h1_v0, h1_v0_rot, h1_v1, h1_v2, h1_v3;
  logic [63:0] h2_v0, h2_v1, h2_v2, h2_v3;

  // First half: two independent add-rotate-xor lanes.
  assign h1_v0     = v0_i + v1_i;
  assign h1_v1     = rotl64(v1_i, ROT_V1_A) ^ h1_v0;
  assign h1_v0_rot = rotl64(h1_v0, ROT_HALF);
  assign h1_v2     = v2_i + v3_i;
  assign h1_v3     = rotl64(v3_i, ROT_V3_A) ^ h1_v2;

  // Second half: lanes cross over.
  assign h2_v0 = h1_v0_rot + h1_v3;
  assign h2_v3 = rotl64(h1_v3, ROT_V3_B) ^ h2_v0;
  assign h2_v2 = h1_v2 + h1_v1;
  assign h2_v1 = rotl64(h1_v1, ROT_V1_B) ^ h2_v2;

  assign v0_o = h2_v0;
  assign v1_o = h2_v1;
  assign v2_o = rotl64(h2_v2, ROT_HALF);
  assign v3_o = h2_v3;

endmodule

// File: rtl/siphash_core.sv
// -----------------------------------------------------------------------------
// siphash_core
// SipHash-2-4 MAC over a stream of 64-bit little-endian message words,
// producing a 64-bit tag. One SipRound per clock through a single shared
// combinational round; two rounds per message word, four for finalisation.
// Ports:
//   clk        in    1    clock, rising edge
//   rst        in    1    synchronous active-high reset
//   key        in  128    {k1, k0}; sampled only when start is accepted
//   start      in    1    begin a new message (accepted in IDLE or DONE)
//   m_valid    in    1    message word valid
//   m_ready    out   1    core accepts a word (high only while absorbing)
//   m_data     in   64    message word, byte 0 in bits [7:0]
//   m_last     in    1    final word of the message
//   m_bytes    in    4    valid low bytes of final word (0..8, 9..15 == 8)
//   tag        out  64    SipHash-2-4 result
//   tag_valid  out   1    tag valid until next accepted start or reset
// -----------------------------------------------------------------------------
module siphash_core
  import siphash_core_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic         start,
  input  logic         m_valid,
  output logic         m_ready,
  input  logic [63:0]  m_data,
  input  logic         m_last,
  input  logic [3:0]   m_bytes,
  output logic [63:0]  tag,
  output logic         tag_valid
);

  state_e     state_q,     state_d;
  sip_state_t v_q,         v_d;
  logic [63:0] b_q,        b_d;
  blk_kind_e  kind_q,      kind_d;
  logic [7:0] len_q,       len_d;
  logic [1:0] fin_cnt_q,   fin_cnt_d;
  logic [63:0] tag_q,      tag_d;
  logic       tag_valid_q, tag_valid_d;
  logic       m_ready_q,   m_ready_d;

  sip_state_t  rnd_in, rnd_out;
  logic [3:0]  eff_bytes;
  logic [7:0]  len_total;
  logic [63:0] tail;
  logic [63:0] word_blk;
  logic [63:0] pad_blk;
  logic        xfer;

  sip_round_comb u_round (
    .v0_i (rnd_in.v0),
    .v1_i (rnd_in.v1),
    .v2_i (rnd_in.v2),
    .v3_i (rnd_in.v3),
    .v0_o (rnd_out.v0),
    .v1_o (rnd_out.v1),
    .v2_o (rnd_out.v2),
    .v3_o (rnd_out.v3)
  );

  assign xfer    = m_valid & m_ready_q;
  // Length-only block used when the message ended on a full word.
  assign pad_blk = {len_q, 56'b0};

  // Block formation for the incoming word. A final word shorter than 8 bytes
  // carries the total length in its top byte; the unused bytes below it are
  // masked off so garbage on m_data cannot leak into the hash.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path (defaults
    // first); otherwise synthesis infers a latch to hold the old value.
    eff_bytes = (m_bytes > 4'd8) ? 4'd8 : m_bytes;
    len_total = len_q + {4'b0, eff_bytes};
    tail      = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < eff_bytes) tail[i*8 +: 8] = m_data[i*8 +: 8];
    end
    if (m_last && (eff_bytes < 4'd8)) word_blk = {len_total, 56'b0} | tail;
    else                              word_blk = m_data;
  end

  // Round input: the first round of a compression folds the block into v3,
  // every other round runs on the registered state as is.
  always_comb begin
    rnd_in = v_q;
    case (state_q)
      ST_ABSORB: rnd_in.v3 = v_q.v3 ^ word_blk;
      ST_PAD:    rnd_in.v3 = v_q.v3 ^ pad_blk;
      default:   ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    b_d         = b_q;
    kind_d      = kind_q;
    len_d       = len_q;
    fin_cnt_d   = fin_cnt_q;
    tag_d       = tag_q;
    tag_valid_d = tag_valid_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          v_d.v0      = key[63:0]   ^ V0_INIT;
          v_d.v1      = key[127:64] ^ V1_INIT;
          v_d.v2      = key[63:0]   ^ V2_INIT;
          v_d.v3      = key[127:64] ^ V3_INIT;
          len_d       = '0;
          fin_cnt_d   = '0;
          tag_valid_d = 1'b0;
          state_d     = ST_ABSORB;
        end
      end

      ST_ABSORB: begin
        if (xfer) begin
          v_d   = rnd_out;
          b_d   = word_blk;
          len_d = m_last ? len_total : len_q + 8'd8;
          if (!m_last)               kind_d = BLK_MID;
          else if (eff_bytes == 4'd8) kind_d = BLK_LAST_FULL;
          else                       kind_d = BLK_LAST;
          state_d = ST_C2;
        end
      end

      ST_C2: begin
        v_d    = rnd_out;
        v_d.v0 = rnd_out.v0 ^ b_q;
        case (kind_q)
          BLK_MID:       state_d = ST_ABSORB;
          BLK_LAST_FULL: state_d = ST_PAD;
          default: begin
            v_d.v2    = rnd_out.v2 ^ FIN_XOR;
            fin_cnt_d = '0;
            state_d   = ST_FIN;
          end
        endcase
      end

      // First round of the length-only block; C2 then finishes it.
      ST_PAD: begin
        v_d     = rnd_out;
        b_d     = pad_blk;
        kind_d  = BLK_LAST;
        state_d = ST_C2;
      end

      ST_FIN: begin
        v_d       = rnd_out;
        fin_cnt_d = fin_cnt_q + 2'd1;
        if (fin_cnt_q == 2'd3) begin
          tag_d       = rnd_out.v0 ^ rnd_out.v1 ^ rnd_out.v2 ^ rnd_out.v3;
          tag_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Registered so m_ready is a clean flop output that tracks ABSORB exactly.
    m_ready_d = (state_d == ST_ABSORB);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // its pre-edge inputs; blocking here would create order-dependent races.
    if (rst) begin
      state_q     <= ST_IDLE;
      v_q         <= '0;
      b_q         <= '0;
      kind_q      <= BLK_MID;
      len_q       <= '0;
      fin_cnt_q   <= '0;
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
      m_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      b_q         <= b_d;
      kind_q      <= kind_d;
      len_q       <= len_d;
      fin_cnt_q   <= fin_cnt_d;
      tag_q       <= tag_d;
      tag_valid_q <= tag_valid_d;
      m_ready_q   <= m_ready_d;
    end
  end

  assign m_ready   = m_ready_q;
  assign tag       = tag_q;
  assign tag_valid = tag_valid_q;

endmodule

// File: doc/siphash_core.md
SIPHASH_CORE -- requirements
Module: siphash_core

Interface
REQ-001 SHALL have no parameters; fixed to SipHash-2-4 with a 64-bit tag.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 key  input  128  key[63:0]=k0, key[127:64]=k1 (little-endian); sampled only on accepted start.
REQ-005 start  input  1  begin new message; accepted only in IDLE or DONE.
REQ-006 m_valid  input  1  message word valid.
REQ-007 m_ready  output  1  core can accept a word; high only in ABSORB.
REQ-008 m_data  input  64  message word, byte 0 in bits [7:0].
REQ-009 m_last  input  1  marks final word of the message.
REQ-010 m_bytes  input  4  valid low bytes of the final word, 0..8; ignored when m_last=0.
REQ-011 tag  output  64  SipHash-2-4 result.
REQ-012 tag_valid  output  1  tag valid; held until next accepted start or reset.

Function
REQ-013 States SHALL be IDLE, ABSORB, C2, PAD, FIN, DONE.
REQ-014 Accepted start SHALL load v0=k0^0x736f6d6570736575, v1=k1^0x646f72616e646f6d, v2=k0^0x6c7967656e657261, v3=k1^0x7465646279746573, clear length counter and tag_valid, enter ABSORB.
REQ-015 Word transfer SHALL occur on edges with m_valid & m_ready; no transfer otherwise, v-state held.
REQ-016 Byte length counter SHALL be 8 bits, +8 per full word, +m_bytes on final partial word, wrapping mod 256.
REQ-017 Block b for a non-final word or final word with m_bytes>=8 SHALL be m_data; values 9..15 SHALL be treated as 8.
REQ-018 Final word with m_bytes<8 SHALL form b = {len_total[7:0], 56'b0} | (m_data masked to low m_bytes bytes).
REQ-019 On transfer SHALL register v <= SipRound(v0,v1,v2,v3^b), latch b, go to C2.
REQ-020 C2 SHALL apply v <= SipRound(v), then v0 ^= b; next state ABSORB if block non-final, PAD if final word had m_bytes>=8, else FIN with v2 ^= 0xff.
REQ-021 PAD SHALL compress b={len_total,56'b0} over two cycles (PAD round with v3^b, then C2 semantics ending in FIN).
REQ-022 FIN SHALL apply four SipRounds on consecutive cycles via a 2-bit counter; on the fourth, tag <= v0^v1^v2^v3 of the round output, tag_valid <= 1, enter DONE.
REQ-023 Latency: final partial-word transfer edge E0 -> tag_valid high after E5; full-8 final word -> after E7.
REQ-024 Throughput: one word per 2 cycles in steady state.
REQ-025 start outside IDLE/DONE SHALL be ignored; key changes mid-message SHALL have no effect.
REQ-026 start in DONE SHALL clear tag_valid on the same edge; tag value may persist but is invalid.
REQ-027 All arithmetic SHALL be mod 2^64; rotations per SipRound constants 13,16,21,17,32.

Reset
REQ-028 rst SHALL force IDLE, v0..v3=0, tag=0, tag_valid=0, m_ready=0, counters=0, from any state including mid-message.
REQ-029 First start SHALL be accepted on the cycle after rst deasserts.

Structure
REQ-030 Shared package SHALL hold the four init constants, the 0xff finalisation constant, rotation amounts, and the state enum.
REQ-031 One combinational sub-module sip_round_comb (4x64 in, 4x64 out, no registers) SHALL be instantiated once and shared by all states.

Verification
REQ-032 key 0x0f0e..0100 (bytes 00..0f), empty message (m_last, m_bytes=0) -> tag 0x726fdb47dd0e0e31, tag_valid 5 cycles after transfer edge.
REQ-033 same key, 1 byte 0x00 -> tag 0x74f839c593dc67fd.
REQ-034 same key, 8 bytes 00..07 (m_data 0x0706050403020100, m_bytes=8) -> PAD path taken, tag 0x93f5f5799a932462, latency 7.
REQ-035 m_valid toggled randomly during 64-byte message -> tag matches golden model; m_ready low in C2/PAD/FIN.
REQ-036 rst asserted in FIN, then new start -> old tag never presented, new tag correct.
REQ-037 start pulses while busy and key changed mid-message -> ignored, tag matches original key.
